// File: rtl/progmem_loadable.sv
// Loadable ToyRISC instruction memory: valid/ready word loader plus registered, stallable fetch port.
// Optional per-word even parity when PROGMEM_PARITY_EN is defined.
module progmem_loadable #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DEPTH      = 65536
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_start,
   input  logic [ADDR_WIDTH-1:0] load_base,
   input  logic [ADDR_WIDTH:0]   load_count,
   input  logic                  load_valid,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_ready,
   output logic                  load_done,
   output logic                  busy,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   input  logic                  fetch_stall,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic                  instr_valid,
`ifdef PROGMEM_PARITY_EN
   output logic                  fetch_oob,
   output logic                  parity_err
`else
   output logic                  fetch_oob
`endif
);

   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PROGMEM_PARITY_EN
   localparam int unsigned MemW = DATA_WIDTH + 1;
`else
   localparam int unsigned MemW = DATA_WIDTH;
`endif
   localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] LastW  = (ADDR_WIDTH + 1)'(DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
   logic [ADDR_WIDTH:0]     rem_q, rem_d;
   logic                    load_ready_q, load_ready_d;
   logic                    load_done_q, load_done_d;
   logic                    busy_q, busy_d;
   logic [DATA_WIDTH-1:0]   instr_q, instr_d;
   logic                    valid_q, valid_d;
   logic                    oob_q, oob_d;
`ifdef PROGMEM_PARITY_EN
   logic                    perr_q, perr_d;
`endif

   logic                    mem_we;
   logic [MemW-1:0]         mem_wdata;
   logic [MemW-1:0]         rd_word;
   logic                    fetch_in_range;
   logic [MemW-1:0]         mem [DEPTH];

`ifdef PROGMEM_PARITY_EN
   assign mem_wdata = {^load_data, load_data};
`else
   assign mem_wdata = load_data;
`endif
   assign rd_word        = mem[fetch_addr[IdxW-1:0]];
   assign fetch_in_range = {1'b0, fetch_addr} < DepthW;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      mem_we  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (load_start) begin
               if (load_count == '0) begin
                  state_d = StDone;
               end else begin
                  ptr_d   = ADDR_WIDTH'({1'b0, load_base} % DepthW);
                  rem_d   = load_count;
                  state_d = StLoad;
               end
            end
         end
         StLoad: begin
            if (load_valid) begin
               mem_we = 1'b1;
               ptr_d  = ({1'b0, ptr_q} == LastW) ? '0 : ptr_q + ADDR_WIDTH'(1);
               rem_d  = rem_q - (ADDR_WIDTH + 1)'(1);
               if (rem_q == (ADDR_WIDTH + 1)'(1)) state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      load_ready_d = (state_d == StLoad);
      load_done_d  = (state_d == StDone);
      busy_d       = (state_d != StIdle);
   end

   // Fetch is only served from IDLE, so a read can never collide with a loader write.
   always_comb begin
      instr_d = instr_q;
      valid_d = 1'b0;
      oob_d   = 1'b0;
`ifdef PROGMEM_PARITY_EN
      perr_d  = 1'b0;
`endif
      if (state_q == StIdle) begin
         if (fetch_stall) begin
            valid_d = valid_q;
            oob_d   = oob_q;
`ifdef PROGMEM_PARITY_EN
            perr_d  = perr_q;
`endif
         end else if (fetch_req) begin
            valid_d = 1'b1;
            if (!fetch_in_range) begin
               instr_d = '0;
               oob_d   = 1'b1;
            end else begin
               instr_d = rd_word[DATA_WIDTH-1:0];
`ifdef PROGMEM_PARITY_EN
               perr_d  = ^rd_word;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         ptr_q        <= '0;
         rem_q        <= '0;
         load_ready_q <= 1'b0;
         load_done_q  <= 1'b0;
         busy_q       <= 1'b0;
         instr_q      <= '0;
         valid_q      <= 1'b0;
         oob_q        <= 1'b0;
`ifdef PROGMEM_PARITY_EN
         perr_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         rem_q        <= rem_d;
         load_ready_q <= load_ready_d;
         load_done_q  <= load_done_d;
         busy_q       <= busy_d;
         instr_q      <= instr_d;
         valid_q      <= valid_d;
         oob_q        <= oob_d;
`ifdef PROGMEM_PARITY_EN
         perr_q       <= perr_d;
`endif
      end
   end

   // Storage is deliberately outside the reset domain.
   always_ff @(posedge clk) begin
      if (mem_we) mem[ptr_q[IdxW-1:0]] <= mem_wdata;
   end

   assign load_ready  = load_ready_q;
   assign load_done   = load_done_q;
   assign busy        = busy_q;
   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign fetch_oob   = oob_q;
`ifdef PROGMEM_PARITY_EN
   assign parity_err  = perr_q;
`endif

endmodule

// File: tb/tb_progmem_loadable.sv
// Scoreboard bench for progmem_loadable: a reference model pushes expected outputs per cycle,
// a negedge monitor pops and compares. Parity checks are included when PROGMEM_PARITY_EN is set.
module tb_progmem_loadable;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 16;
   localparam int unsigned D  = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load_start, load_valid, fetch_req, fetch_stall;
   logic [AW-1:0] load_base, fetch_addr;
   logic [AW:0]   load_count;
   logic [DW-1:0] load_data;
   logic          load_ready, load_done, busy, instr_valid, fetch_oob;
   logic [DW-1:0] instruction;
   logic          parity_err;

   always #5 clk = ~clk;

   progmem_loadable #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_start  (load_start),
      .load_base   (load_base),
      .load_count  (load_count),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .load_done   (load_done),
      .busy        (busy),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_stall (fetch_stall),
      .instruction (instruction),
      .instr_valid (instr_valid),
`ifdef PROGMEM_PARITY_EN
      .fetch_oob   (fetch_oob),
      .parity_err  (parity_err)
`else
      .fetch_oob   (fetch_oob)
`endif
   );
`ifndef PROGMEM_PARITY_EN
   assign parity_err = 1'b0;
`endif

   typedef struct {
      logic [DW-1:0] instr;
      bit            valid, oob, perr, busy, ready, done;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model state: memory image, loader progress, last fetch result.
   logic [DW-1:0] m_mem [D];
   bit            m_wr  [D];
   bit            m_bad [D];
   int            m_st;            // 0 idle, 1 loading, 2 done pulse
   int unsigned   m_ptr, m_rem;
   logic [DW-1:0] m_instr;
   bit            m_valid, m_oob, m_perr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_st = 0; m_instr = '0; m_valid = 0; m_oob = 0; m_perr = 0;
   endfunction

   // Advance one clock edge and record what the spec says the outputs become.
   task automatic step();
      exp_t e;
      @(posedge clk);
      if (m_st == 0) begin
         if (fetch_stall) begin
         end else if (fetch_req) begin
            m_valid = 1;
            if (fetch_addr >= D) begin
               m_instr = '0; m_oob = 1; m_perr = 0;
            end else begin
               m_instr = m_mem[fetch_addr]; m_oob = 0; m_perr = m_bad[fetch_addr];
            end
         end else begin
            m_valid = 0; m_oob = 0; m_perr = 0;
         end
      end else begin
         m_valid = 0; m_oob = 0; m_perr = 0;
      end
      case (m_st)
         0: if (load_start) begin
               if (load_count == 0) m_st = 2;
               else begin
                  m_ptr = load_base % D; m_rem = load_count; m_st = 1;
               end
            end
         1: if (load_valid) begin
               m_mem[m_ptr] = load_data; m_wr[m_ptr] = 1; m_bad[m_ptr] = 0;
               m_ptr = (m_ptr + 1) % D;
               m_rem--;
               if (m_rem == 0) m_st = 2;
            end
         default: m_st = 0;
      endcase
      e.instr = m_instr; e.valid = m_valid; e.oob = m_oob; e.perr = m_perr;
      e.busy = (m_st != 0); e.ready = (m_st == 1); e.done = (m_st == 2);
      q.push_back(e);
      #1;
   endtask

   task automatic idle_inputs();
      load_start = 0; load_base = '0; load_count = '0; load_valid = 0; load_data = '0;
      fetch_req = 0; fetch_addr = '0; fetch_stall = 0;
   endtask

   task automatic fetch(input int unsigned a);
      fetch_req = 1; fetch_addr = AW'(a); step(); fetch_req = 0;
   endtask

   task automatic load(input int unsigned base, input int unsigned cnt, input logic [DW-1:0] w0,
                       input logic [DW-1:0] w1, input logic [DW-1:0] w2);
      load_start = 1; load_base = AW'(base); load_count = (AW + 1)'(cnt); step();
      load_start = 0; load_valid = 1;
      for (int i = 0; i < int'(cnt); i++) begin
         load_data = (i == 0) ? w0 : (i == 1) ? w1 : w2;
         step();
      end
      load_valid = 0;
      step(); step();
   endtask

   task automatic check_reset();
      chk("rst_instruction", instruction, 0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_fetch_oob", fetch_oob, 0);
      chk("rst_parity_err", parity_err, 0);
      chk("rst_load_ready", load_ready, 0);
      chk("rst_load_done", load_done, 0);
      chk("rst_busy", busy, 0);
   endtask

   always @(negedge clk) begin
      if (rst_n && q.size() != 0) begin
         mon_e = q.pop_front();
         chk("instr_valid", instr_valid, mon_e.valid);
         chk("instruction", instruction, mon_e.instr);
         chk("fetch_oob", fetch_oob, mon_e.oob);
         chk("busy", busy, mon_e.busy);
         chk("load_ready", load_ready, mon_e.ready);
         chk("load_done", load_done, mon_e.done);
`ifdef PROGMEM_PARITY_EN
         chk("parity_err", parity_err, mon_e.perr);
`endif
      end
   end

   initial begin
      int unsigned r;
      idle_inputs();
      model_reset();
      for (int i = 0; i < int'(D); i++) begin
         m_wr[i] = 0; m_bad[i] = 0; m_mem[i] = '0;
      end
      #12;
      check_reset();
      rst_n = 1;

      // Basic load and fetch
      load(0, 3, 32'h5C00_0005, 32'h0C01_001F, 32'h1CA0_001F);
      fetch(1);
      step();

      // Stall freezes the result while the address moves, then an idle cycle clears valid
      fetch(0);
      fetch_stall = 1; fetch_req = 1;
      for (int i = 0; i < 3; i++) begin
         fetch_addr = AW'(i + 1); step();
      end
      fetch_stall = 0; fetch_req = 0; step();

      // Out-of-bounds fetch and zero-count load
      fetch(20);
      step();
      load_start = 1; load_count = '0; step(); load_start = 0;
      step(); step();
      fetch(2);

      // Wrap-around
      load(15, 2, 32'hAAAA_AAAA, 32'h5555_5555, '0);
      fetch(15);
      fetch(0);
      step();

      // Reset after two of four words
      load_start = 1; load_base = '0; load_count = 4; step();
      load_start = 0; load_valid = 1;
      load_data = 32'h1111_0000; step();
      load_data = 32'h2222_0000; step();
      rst_n = 0;
      q.delete();
      model_reset();
      idle_inputs();
      #2;
      check_reset();
      #10;
      rst_n = 1;
      fetch(0); fetch(1); fetch(2);
      step();

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         load_start = ($urandom % 8) == 0;
         load_base  = AW'($urandom);
         load_count = (AW + 1)'($urandom_range(20, 0));
         load_valid = ($urandom % 4) != 0;
         load_data  = $urandom;
         fetch_req  = $urandom % 2;
         fetch_stall = ($urandom % 4) == 0;
         r = $urandom_range(D - 1, 0);
         if (!m_wr[r] || ($urandom % 6) == 0) fetch_addr = AW'($urandom_range(65535, D));
         else fetch_addr = AW'(r);
         step();
      end
      idle_inputs();
      load_valid = 1;
      for (int i = 0; i < 25; i++) step();
      idle_inputs();
      step();

`ifdef PROGMEM_PARITY_EN
      load(5, 2, 32'h0000_0001, 32'h0000_0003, '0);
      dut.mem[5][3] = ~dut.mem[5][3];
      m_mem[5] = m_mem[5] ^ 32'h8;
      m_bad[5] = 1;
      fetch(5);
      fetch(6);
      step();
`endif

      @(negedge clk);
      #1;
      chk("scoreboard_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/progmem_loadable.md
# progmem_loadable

Parametrised, loadable instruction memory for the ToyRISC fetch stage. It is the successor to the fixed, reset-initialised program memory. Program words are streamed in at run time through a valid/ready loader port, and instructions are read out through a registered fetch port with stall. Reset no longer touches memory contents.

## Interface
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 16, fetch/load address width
- DEPTH, 65536, number of words; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_WIDTH

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- load_start  in  1  one-cycle pulse; begins a load (sampled in IDLE only)
- load_base  in  ADDR_WIDTH  first write address, sampled with load_start
- load_count  in  ADDR_WIDTH+1  number of words to load, sampled with load_start
- load_valid  in  1  load_data valid
- load_data  in  DATA_WIDTH  word to write
- load_ready  out  1  loader accepts a word this cycle
- load_done  out  1  one-cycle pulse at end of load
- busy  out  1  high while a load is in progress (LOAD or DONE)
- fetch_req  in  1  read request
- fetch_addr  in  ADDR_WIDTH  read address
- fetch_stall  in  1  hold the current fetch output
- instruction  out  DATA_WIDTH  fetched word, registered
- instr_valid  out  1  instruction carries a new fetch result
- fetch_oob  out  1  fetch_addr ≥ DEPTH; qualifies instr_valid
- parity_err  out  1  present only with PROGMEM_PARITY_EN

## Operation
- Storage is a `mem` array of DEPTH words. Reset does not clear it; its contents are undefined until loaded.
- Loader FSM has three states: IDLE, LOAD and DONE.
  - IDLE: load_start with load_count≠0 latches ptr=load_base and remaining=load_count, then goes to LOAD. load_start with load_count=0 goes to DONE and performs no writes.
  - LOAD: load_ready=1. Each load_valid&&load_ready writes mem[ptr]=load_data, increments ptr modulo DEPTH (DEPTH−1 wraps to 0), and decrements remaining. After the write that brings remaining to 0, the FSM goes to DONE. load_valid low inserts wait cycles with no write.
  - DONE: load_done=1 for one cycle, then the FSM returns to IDLE.
  - load_start is ignored outside IDLE.
  - load_base ≥ DEPTH is reduced modulo DEPTH.
- Fetch, in IDLE only:
  - fetch_stall has priority. While it is high, instruction, instr_valid, fetch_oob and parity_err hold their values.
  - Otherwise, fetch_req loads instruction=mem[fetch_addr] and sets instr_valid=1.
  - If fetch_addr ≥ DEPTH, instruction=0 (NOP), instr_valid=1 and fetch_oob=1.
  - With no fetch_req and no stall, instr_valid=0, fetch_oob=0, and instruction holds its last value.
- Fetch while busy: fetch_req is ignored, instr_valid=0, and instruction holds its value. This means read-during-write cannot occur.

## Timing
- Reset values: instruction=0, instr_valid=0, fetch_oob=0, parity_err=0, load_ready=0, load_done=0, busy=0, FSM=IDLE.
- Fetch latency is 1 cycle: a fetch_req at edge N produces its result after edge N+1.
- Loader timing:
  - load_ready and busy rise 1 cycle after load_start is accepted.
  - A load of K words with load_valid held high takes K LOAD cycles, followed by 1 DONE cycle.
  - load_done is high in the cycle after the last write.
  - busy falls together with load_done.
- Reset asserted mid-load: the FSM returns to IDLE immediately. Words already written remain; unwritten words are unchanged.
- load_start and fetch_req in the same IDLE cycle: the fetch is served (result valid next cycle) and the load starts. This is the last fetch served until the FSM is back in IDLE.

## Configuration
- PROGMEM_PARITY_EN defined:
  - Each stored word is DATA_WIDTH+1 bits wide: the data plus an even-parity bit computed at write time.
  - On fetch, parity_err=1 alongside instr_valid if the recomputed parity mismatches. It is 0 for out-of-bounds fetches.
  - parity_err follows the same hold/clear rules as fetch_oob.
- PROGMEM_PARITY_EN undefined: the parity_err port and the parity bit do not exist, and storage is DATA_WIDTH bits wide.

## Test plan
- Basic load and fetch: reset, then load_start base=0 count=3 with data 0x5C00_0005, 0x0C01_001F, 0x1CA0_001F, valid held high. Required: 3 write cycles, load_done at cycle 5 after start. Fetch addr 1 → instruction=0x0C01_001F, instr_valid=1 one cycle later.
- Wrap-around: DEPTH=16, base=15, count=2, data 0xAAAA_AAAA then 0x5555_5555. Required: fetch 15 → 0xAAAA_AAAA, fetch 0 → 0x5555_5555.
- Stall and idle behaviour: fetch addr 0 with fetch_stall raised the following cycle for 3 cycles while fetch_addr changes. Required: instruction and instr_valid=1 frozen for 3 cycles. A subsequent idle cycle gives instr_valid=0 with instruction unchanged.
- Boundary fetches and zero-count load: DEPTH=16, fetch addr 20 → instruction=0, fetch_oob=1. load_count=0 → load_done after 1 cycle, no memory change, busy high for exactly 1 cycle.
- Reset during load: assert reset after 2 of 4 words. Required: all outputs at reset values, FSM=IDLE, words 0–1 readable, word 2 unchanged.
- Parity error (PROGMEM_PARITY_EN): load 0x0000_0001, flip a stored data bit via hierarchical deposit into mem, then fetch. Required: parity_err=1 with instr_valid=1. An intact word gives parity_err=0.
